energy_detector_mc: RTL and testbench
=====================================

Name: energy_detector_mc

Overview:
Multi-channel windowed energy detector for spectrum sensing. It generalises the single-channel detector: it handles NCH parallel complex streams and a run-time window length, and gates samples with a valid qualifier. It reports per-channel window energy and a hysteretic, debounced occupancy decision. It sits after the channeliser/DDC and feeds the spectrum-occupancy controller.

Parameters:
WL, 16, bit width of each signed I/Q sample.
NCH, 4, number of parallel channels.
NMAX, 1024, maximum window length in samples.
CW, $clog2(NMAX+1), width of the window-length port.
AW, 2*WL+1+$clog2(NMAX), accumulator and threshold width.
HW, 4, width of the debounce hold count.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
in_valid  in  1  sample strobe; all channels are sampled together
in_re  in  NCH*WL  packed signed I samples; channel k is at [k*WL +: WL]
in_im  in  NCH*WL  packed signed Q samples; same packing as in_re
win_len  in  CW  window length in samples; latched at the first sample of each window
thr_hi  in  AW  unsigned assert threshold, shared by all channels
thr_lo  in  AW  unsigned deassert threshold, shared by all channels
hold  in  HW  consecutive qualifying windows required, minus one
out_valid  out  1  one-cycle pulse at the end of each window
out_energy  out  NCH*AW  per-channel window energy; valid while out_valid=1
detected  out  NCH  per-channel occupancy state; level signal

Behaviour:
- Reset values: out_valid=0, out_energy=0, detected=0, all accumulators=0, sample counter=0, debounce streak counters=0.
- Reset asserted mid-window discards the partial window. The next accepted sample starts a new window.
- Per-sample energy: e = re*re + im*im, computed in full precision as unsigned 2*WL+1 bits.
  - The worst case (-2^(WL-1)) on both I and Q equals 2^(2WL-1) and must not wrap.
- The accumulator is unsigned AW bits. It cannot overflow for any window length up to NMAX.
- Sample acceptance:
  - A sample is accepted only on a cycle with in_valid=1.
  - in_valid=0 stalls the window: the counter and accumulators hold.
- Window length:
  - win_len is latched on the first accepted sample of a window (counter=0). Changes mid-window are ignored.
  - win_len=0 is treated as 1. win_len>NMAX is clamped to NMAX.
- Window end: on the accepted sample with counter = latched length - 1:
  - The next cycle has out_valid=1 and out_energy[k] = sum of all samples in the window, including the last one.
  - Accumulators and the counter clear in that same cycle, so the following window may start on the very next cycle with no bubble.
  - Latency from the last sample to out_valid is 1 cycle.
- out_energy holds its value until the next window end. out_valid is never asserted for two consecutive cycles unless the window length is 1.
- thr_hi, thr_lo and hold are sampled at the window end.
- Per-channel decision FSM, with states OFF and ON and a streak counter of width HW+1:
  - OFF: if E > thr_hi, streak increments, else streak clears. When streak reaches hold+1, go to ON and clear streak.
  - ON: if E < thr_lo, streak increments, else streak clears. When streak reaches hold+1, go to OFF and clear streak.
  - detected[k] = 1 exactly while in ON. It updates on the same cycle out_valid rises.
  - Comparisons are strict. E equal to either threshold is not qualifying.
  - thr_lo > thr_hi is legal, and each state checks only its own threshold.
- Channels are fully independent, except for the shared counter and thresholds.
- No $finish, delays or other simulation-only constructs. The block is fully synthesizable.

Decomposition:
- Package ed_pkg: function for AW, saturating clamp function for win_len, and an enum for the OFF/ON state.
- Sub-module ed_channel: one squarer, accumulator, hysteresis FSM and streak counter. It is instantiated NCH times via generate.
- The top level owns the window counter, latched length, threshold sampling and out_valid generation.

Test Plan:
1. NCH=2, win_len=4, ch0 re=100 im=0 and ch1 re=im=0 with continuous valid, thr_hi=30000, thr_lo=10000, hold=0 -> out_valid one cycle after the 4th sample; out_energy[0]=40000, out_energy[1]=0; detected=2'b01.
2. Same stimulus, with in_valid toggling 1,0,1,0 -> identical energies; out_valid occurs 1 cycle after the 4th accepted sample.
3. ch0 re=im=-32768, win_len=1024 -> out_energy[0]=2^41 exactly, no wrap.
4. Hysteresis with hold=1:
   - Window energies 40000, 20000, 40000, 40000 -> detected[0] rises only at window 4.
   - Then 5000, 5000 -> detected[0] falls at the second of those windows.
   - A window energy exactly equal to thr_hi does not count toward the streak.
5. rst pulsed after 2 of 4 samples, then 4 samples of energy 100 -> out_energy[0]=400; detected and streaks are zero after the reset.
6. win_len changed from 4 to 8 mid-window -> the current window ends after 4 samples and the next one after 8. win_len=0 -> out_valid after every sample.

Source files
------------

// File: rtl/ed_pkg.sv
// Shared types and helpers for the multi-channel energy detector.
package ed_pkg;

    typedef enum logic {
        DET_OFF = 1'b0,
        DET_ON  = 1'b1
    } det_state_t;

    function automatic int unsigned calc_aw(input int unsigned wl, input int unsigned nmax);
        return 2 * wl + 1 + $clog2(nmax);
    endfunction

    // Zero-length windows become 1; oversize windows saturate at nmax.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned nmax);
        if (len == 0) begin
            return 1;
        end else if (len > nmax) begin
            return nmax;
        end
        return len;
    endfunction

endpackage

// File: rtl/ed_channel.sv
// One detector lane: squarer, window accumulator and hysteretic debounce FSM.
module ed_channel
    import ed_pkg::*;
#(
    parameter int unsigned WL = 16,
    parameter int unsigned AW = 43,
    parameter int unsigned HW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic                 win_end,
    input  logic signed [WL-1:0] re,
    input  logic signed [WL-1:0] im,
    input  logic [AW-1:0]        thr_hi,
    input  logic [AW-1:0]        thr_lo,
    input  logic [HW-1:0]        hold,
    output logic [AW-1:0]        energy,
    output logic                 detected
);

    localparam int unsigned EW = 2 * WL + 1;
    localparam int unsigned SW = HW + 1;

    logic signed [2*WL-1:0] p_re;
    logic signed [2*WL-1:0] p_im;
    logic [EW-1:0]          e;
    logic [AW-1:0]          acc_q;
    logic [AW-1:0]          sum;

    det_state_t             state_q, state_d;
    logic [SW-1:0]          streak_q, streak_d;
    logic [SW-1:0]          streak_inc;
    logic [SW-1:0]          target;
    logic                   qualify;

    // Squares are non-negative, so the sum of the two fits 2*WL+1 bits without wrap.
    assign p_re = re * re;
    assign p_im = im * im;
    assign e    = {1'b0, p_re} + {1'b0, p_im};
    assign sum  = acc_q + AW'(e);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            energy <= '0;
        end else if (sample_en) begin
            if (win_end) begin
                energy <= sum;
                acc_q  <= '0;
            end else begin
                acc_q  <= sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DET_OFF;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    assign streak_inc = streak_q + SW'(1);
    assign target     = SW'(hold) + SW'(1);

    // Each state watches only its own threshold; equality never qualifies.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        qualify  = 1'b0;
        if (win_end) begin
            qualify = (state_q == DET_OFF) ? (sum > thr_hi) : (sum < thr_lo);
            if (qualify) begin
                if (streak_inc >= target) begin
                    state_d  = (state_q == DET_OFF) ? DET_ON : DET_OFF;
                    streak_d = '0;
                end else begin
                    streak_d = streak_inc;
                end
            end else begin
                streak_d = '0;
            end
        end
    end

    assign detected = (state_q == DET_ON);

endmodule

// File: rtl/energy_detector_mc.sv
// Multi-channel windowed energy detector: shared window timing, per-channel lanes.
module energy_detector_mc
    import ed_pkg::*;
#(
    parameter int unsigned WL   = 16,
    parameter int unsigned NCH  = 4,
    parameter int unsigned NMAX = 1024,
    parameter int unsigned CW   = $clog2(NMAX + 1),
    parameter int unsigned AW   = calc_aw(WL, NMAX),
    parameter int unsigned HW   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [NCH*WL-1:0]   in_re,
    input  logic [NCH*WL-1:0]   in_im,
    input  logic [CW-1:0]       win_len,
    input  logic [AW-1:0]       thr_hi,
    input  logic [AW-1:0]       thr_lo,
    input  logic [HW-1:0]       hold,
    output logic                out_valid,
    output logic [NCH*AW-1:0]   out_energy,
    output logic [NCH-1:0]      detected
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] len_cur_c;
    logic          last_c;

    // The live length is taken from the port only on the first sample of a window.
    assign len_cur_c = (cnt_q == '0) ? CW'(clamp_len(32'(win_len), NMAX)) : len_q;
    assign last_c    = in_valid && (cnt_q == len_cur_c - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= last_c;
            if (in_valid) begin
                if (cnt_q == '0) begin
                    len_q <= len_cur_c;
                end
                cnt_q <= last_c ? '0 : cnt_q + CW'(1);
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        ed_channel #(
            .WL (WL),
            .AW (AW),
            .HW (HW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .sample_en (in_valid),
            .win_end   (last_c),
            .re        (in_re[k*WL +: WL]),
            .im        (in_im[k*WL +: WL]),
            .thr_hi    (thr_hi),
            .thr_lo    (thr_lo),
            .hold      (hold),
            .energy    (out_energy[k*AW +: AW]),
            .detected  (detected[k])
        );
    end

endmodule

// File: tb/tb_energy_detector_mc.sv
// Directed bench for energy_detector_mc with two channels.
module tb_energy_detector_mc;

    localparam int unsigned WL   = 16;
    localparam int unsigned NCH  = 2;
    localparam int unsigned NMAX = 1024;
    localparam int unsigned CW   = 11;
    localparam int unsigned AW   = 43;
    localparam int unsigned HW   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [NCH*WL-1:0]   in_re;
    logic [NCH*WL-1:0]   in_im;
    logic [CW-1:0]       win_len;
    logic [AW-1:0]       thr_hi;
    logic [AW-1:0]       thr_lo;
    logic [HW-1:0]       hold;
    logic                out_valid;
    logic [NCH*AW-1:0]   out_energy;
    logic [NCH-1:0]      detected;
    logic [AW-1:0]       en0;
    logic [AW-1:0]       en1;

    int checks   = 0;
    int failures = 0;

    energy_detector_mc #(
        .WL   (WL),
        .NCH  (NCH),
        .NMAX (NMAX),
        .CW   (CW),
        .AW   (AW),
        .HW   (HW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_re      (in_re),
        .in_im      (in_im),
        .win_len    (win_len),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .hold       (hold),
        .out_valid  (out_valid),
        .out_energy (out_energy),
        .detected   (detected)
    );

    always #5 clk = ~clk;

    assign en0 = out_energy[AW-1:0];
    assign en1 = out_energy[2*AW-1:AW];

    task automatic drive(input logic v, input int r0, input int i0, input int r1, input int i1);
        in_valid = v;
        in_re    = {WL'(r1), WL'(r0)};
        in_im    = {WL'(i1), WL'(i0)};
    endtask

    task automatic run_win(input int n, input int r0, input int i0, input int r1, input int i1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b1, r0, i0, r1, i1);
        end
        @(negedge clk);
        drive(1'b0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", out_valid); end
        checks++; if (en0 !== '0) begin failures++; $display("FAIL reset_e0 got=%0d exp=0", en0); end
        checks++; if (en1 !== '0) begin failures++; $display("FAIL reset_e1 got=%0d exp=0", en1); end
        checks++; if (detected !== 2'b00) begin failures++; $display("FAIL reset_det got=%b exp=00", detected); end
    endtask

    task automatic test_basic();
        win_len = CW'(4);
        thr_hi  = AW'(30000);
        thr_lo  = AW'(10000);
        hold    = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid i=%0d got=%0d exp=0", i, out_valid); end
            end
            drive(1'b1, 100, 0, 0, 0);
        end
        @(negedge clk);
        drive(1'b0, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0d exp=1", out_valid); end
        checks++; if (en0 !== AW'(40000)) begin failures++; $display("FAIL basic_e0 got=%0d exp=40000", en0); end
        checks++; if (en1 !== AW'(0)) begin failures++; $display("FAIL basic_e1 got=%0d exp=0", en1); end
        checks++; if (detected !== 2'b01) begin failures++; $display("FAIL basic_det got=%b exp=01", detected); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%0d exp=0", out_valid); end
        checks++; if (en0 !== AW'(40000)) begin failures++; $display("FAIL basic_hold_e0 got=%0d exp=40000", en0); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_early_valid i=%0d got=%0d exp=0", i, out_valid); end
            end
            if (i % 2 == 0) drive(1'b1, 100, 0, 0, 0);
            else            drive(1'b0, 5000, 5000, 5000, 5000);
        end
        @(negedge clk);
        drive(1'b0, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%0d exp=1", out_valid); end
        checks++; if (en0 !== AW'(40000)) begin failures++; $display("FAIL stall_e0 got=%0d exp=40000", en0); end
        checks++; if (en1 !== AW'(0)) begin failures++; $display("FAIL stall_e1 got=%0d exp=0", en1); end
        checks++; if (detected !== 2'b01) begin failures++; $display("FAIL stall_det got=%b exp=01", detected); end
    endtask

    task automatic test_worst();
        win_len = CW'(1024);
        run_win(1024, -32768, -32768, 32767, -32768);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL worst_valid got=%0d exp=1", out_valid); end
        checks++; if (en0 !== AW'(64'd2199023255552)) begin failures++; $display("FAIL worst_e0 got=%0d exp=2199023255552", en0); end
        checks++; if (en1 !== AW'(64'd2198956147712)) begin failures++; $display("FAIL worst_e1 got=%0d exp=2198956147712", en1); end
        checks++; if (detected !== 2'b11) begin failures++; $display("FAIL worst_det got=%b exp=11", detected); end
    endtask

    task automatic test_hysteresis();
        int re_t  [10] = '{100, 50, 100, 100, 25, 25, 100, 100, 100, 100};
        int im_t  [10] = '{0,   50, 0,   0,   25, 25, 0,   0,   0,   0};
        int hi_t  [10] = '{30000, 30000, 30000, 30000, 30000, 30000, 30000, 40000, 30000, 30000};
        int e_t   [10] = '{40000, 20000, 40000, 40000, 5000, 5000, 40000, 40000, 40000, 40000};
        logic det_t [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        hold    = HW'(1);
        win_len = CW'(4);
        thr_lo  = AW'(10000);
        for (int w = 0; w < 10; w++) begin
            thr_hi = AW'(hi_t[w]);
            run_win(4, re_t[w], im_t[w], 0, 0);
            checks++; if (en0 !== AW'(e_t[w])) begin failures++; $display("FAIL hyst_e0 w=%0d got=%0d exp=%0d", w, en0, e_t[w]); end
            checks++; if (detected !== {1'b0, det_t[w]}) begin failures++; $display("FAIL hyst_det w=%0d got=%b exp=0%b", w, detected, det_t[w]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold    = HW'(1);
        win_len = CW'(4);
        thr_hi  = AW'(30000);
        run_win(4, 100, 0, 0, 0);
        checks++; if (detected !== 2'b00) begin failures++; $display("FAIL rmid_pre_det got=%b exp=00", detected); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 100, 0, 0, 0);
        end
        @(negedge clk);
        drive(1'b0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (en0 !== '0) begin failures++; $display("FAIL rmid_e0_clear got=%0d exp=0", en0); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid_clear got=%0d exp=0", out_valid); end
        thr_hi = AW'(300);
        run_win(4, 10, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_valid got=%0d exp=1", out_valid); end
        checks++; if (en0 !== AW'(400)) begin failures++; $display("FAIL rmid_e0 got=%0d exp=400", en0); end
        checks++; if (detected !== 2'b00) begin failures++; $display("FAIL rmid_det got=%b exp=00", detected); end
    endtask

    task automatic test_len_change();
        int pulses;
        win_len = CW'(4);
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (out_valid !== ((i == 4) || (i == 12))) begin failures++; $display("FAIL len_valid i=%0d got=%0d", i, out_valid); end
            end
            if (i == 4) begin
                checks++; if (en0 !== AW'(400)) begin failures++; $display("FAIL len_e0_first got=%0d exp=400", en0); end
            end
            if (i == 12) begin
                checks++; if (en0 !== AW'(800)) begin failures++; $display("FAIL len_e0_second got=%0d exp=800", en0); end
            end
            if (i == 1) win_len = CW'(8);
            if (i < 12) drive(1'b1, 10, 0, 0, 0);
            else        drive(1'b0, 0, 0, 0, 0);
        end
        // Oversize length saturates at NMAX.
        win_len = '1;
        pulses  = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (i > 0 && out_valid === 1'b1) pulses++;
            drive(1'b1, 1, 0, 0, 0);
        end
        @(negedge clk);
        drive(1'b0, 0, 0, 0, 0);
        checks++; if (pulses != 0) begin failures++; $display("FAIL clamp_early got=%0d exp=0", pulses); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL clamp_valid got=%0d exp=1", out_valid); end
        checks++; if (en0 !== AW'(1024)) begin failures++; $display("FAIL clamp_e0 got=%0d exp=1024", en0); end
    endtask

    task automatic test_back_to_back();
        win_len = '0;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid i=%0d got=%0d exp=1", i, out_valid); end
                checks++; if (en0 !== AW'(i * i)) begin failures++; $display("FAIL b2b_e0 i=%0d got=%0d exp=%0d", i, en0, i * i); end
            end
            if (i < 5) drive(1'b1, i + 1, 0, 0, 0);
            else       drive(1'b0, 0, 0, 0, 0);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0d exp=0", out_valid); end
    endtask

    initial begin
        rst     = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        win_len = CW'(4);
        thr_hi  = AW'(30000);
        thr_lo  = AW'(10000);
        hold    = '0;
        test_reset();
        test_basic();
        test_stall();
        test_worst();
        test_hysteresis();
        test_reset_mid();
        test_len_change();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
